// File: rtl/booth_mult_if.sv
// booth_mult_if: handshake and data bundle between the control unit and the
// sequential Booth multiplier.
//   master : control unit side (drives multStart/A/B, observes busy/done/Hi/Lo)
//   slave  : multiplier side
// Optional macro MULT_MULTU_EN adds the isUnsigned select (sampled with multStart).
interface booth_mult_if #(parameter int WIDTH = 32);
  logic             multStart;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
`ifdef MULT_MULTU_EN
  logic             isUnsigned;
`endif
  logic             multBusy;
  logic             multDone;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

`ifdef MULT_MULTU_EN
  modport master (output multStart, A, B, isUnsigned,
                  input  multBusy, multDone, Hi, Lo);
  modport slave  (input  multStart, A, B, isUnsigned,
                  output multBusy, multDone, Hi, Lo);
`else
  modport master (output multStart, A, B,
                  input  multBusy, multDone, Hi, Lo);
  modport slave  (input  multStart, A, B,
                  output multBusy, multDone, Hi, Lo);
`endif
endinterface

// File: rtl/booth_mult.sv
// booth_mult: sequential radix-2 Booth multiplier, one add/sub + shift per cycle.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : booth_mult_if.slave (multStart, A, B -> multBusy, multDone, Hi, Lo)
// Optional macro MULT_MULTU_EN: adds bus.isUnsigned; unsigned operands are
// zero-extended and take one extra step (WIDTH+1 cycles).
//
// state | meaning
// IDLE  | waiting for multStart
// RUN   | Booth step each cycle, cnt counts remaining steps down to terminal 1
// DONE  | multDone pulse, Hi/Lo just written
module booth_mult #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  booth_mult_if.slave  bus
);

`ifdef MULT_MULTU_EN
  localparam int MW = WIDTH + 1;   // multiplier field holds a zero-extended operand
`else
  localparam int MW = WIDTH;
`endif
  // acc = {upper (WIDTH+1), multiplier field (MW), previous bit}
  localparam int AW = WIDTH + 1 + MW + 1;
  localparam int CW = $clog2(MW + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    acc, acc_step;
  logic [WIDTH:0]   m_reg;
  logic [WIDTH:0]   upper_sum;
  logic [CW-1:0]    cnt;
  logic             last_step;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic [WIDTH-1:0] hi_res, lo_res;
  logic             busy, done;
`ifdef MULT_MULTU_EN
  logic             u_reg;
`endif

  assign last_step = (cnt == CW'(1));

  always_comb begin
    upper_sum = acc[AW-1 -: WIDTH+1];
    case (acc[1:0])
      2'b01:   upper_sum = acc[AW-1 -: WIDTH+1] + m_reg;
      2'b10:   upper_sum = acc[AW-1 -: WIDTH+1] - m_reg;
      default: upper_sum = acc[AW-1 -: WIDTH+1];
    endcase
    acc_step = {upper_sum[WIDTH], upper_sum, acc[AW-WIDTH-2:1]};
  end

  // After s steps on an MW-bit multiplier field the product's LSB sits at
  // acc bit MW-s+1: bit 2 for signed (WIDTH steps, extended field), bit 1 otherwise.
`ifdef MULT_MULTU_EN
  assign lo_res = u_reg ? acc_step[WIDTH:1]         : acc_step[WIDTH+1:2];
  assign hi_res = u_reg ? acc_step[2*WIDTH:WIDTH+1] : acc_step[2*WIDTH+1:WIDTH+2];
`else
  assign lo_res = acc_step[WIDTH:1];
  assign hi_res = acc_step[2*WIDTH:WIDTH+1];
`endif

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: state_nxt = IDLE;
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // a start in any state (re)loads, abandoning an unfinished product
    if (bus.multStart) state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      m_reg  <= '0;
      cnt    <= '0;
      hi_reg <= '0;
      lo_reg <= '0;
`ifdef MULT_MULTU_EN
      u_reg  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (bus.multStart) begin
`ifdef MULT_MULTU_EN
        u_reg <= bus.isUnsigned;
        if (bus.isUnsigned) begin
          m_reg <= {1'b0, bus.A};
          acc   <= {{(WIDTH+1){1'b0}}, 1'b0, bus.B, 1'b0};
          cnt   <= CW'(WIDTH + 1);
        end else begin
          m_reg <= {bus.A[WIDTH-1], bus.A};
          acc   <= {{(WIDTH+1){1'b0}}, bus.B[WIDTH-1], bus.B, 1'b0};
          cnt   <= CW'(WIDTH);
        end
`else
        m_reg <= {bus.A[WIDTH-1], bus.A};
        acc   <= {{(WIDTH+1){1'b0}}, bus.B, 1'b0};
        cnt   <= CW'(WIDTH);
`endif
      end else if (state == RUN) begin
        acc <= acc_step;
        cnt <= cnt - CW'(1);
        if (last_step) begin
          hi_reg <= hi_res;
          lo_reg <= lo_res;
        end
      end
    end
  end

  assign bus.multBusy = busy;
  assign bus.multDone = done;
  assign bus.Hi       = hi_reg;
  assign bus.Lo       = lo_reg;

endmodule

// File: tb/tb_booth_mult.sv
// tb_booth_mult: scoreboard bench for booth_mult (signed; unsigned when MULT_MULTU_EN).
module tb_booth_mult;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  booth_mult_if #(.WIDTH(W)) bus();
  booth_mult #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    bit           uns;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           done_cnt = 0;
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  always @(negedge clk) if (bus.multDone === 1'b1) done_cnt++;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input bit u);
    logic [2*W-1:0] ea, eb;
    ea = u ? {{W{1'b0}}, a} : {{W{a[W-1]}}, a};
    eb = u ? {{W{1'b0}}, b} : {{W{b[W-1]}}, b};
    return ea * eb;
  endfunction

  // called at a negedge; leaves the bench at the negedge after the start edge
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit u,
                             input logic [W-1:0] ehi, input logic [W-1:0] elo);
    exp_t e;
    bus.A = a;
    bus.B = b;
    bus.multStart = 1'b1;
`ifdef MULT_MULTU_EN
    bus.isUnsigned = u;
`endif
    e.hi = ehi; e.lo = elo; e.uns = u; e.lat = u ? W + 1 : W;
    sb.push_back(e);
    @(negedge clk);
    bus.multStart = 1'b0;
  endtask

  task automatic wait_check(input string name);
    int   k = 0;
    bit   seen = 0;
    bit   hold_ok = 1;
    bit   busy_ok = 1;
    exp_t e;
    while (k < 100 && !seen) begin
      @(negedge clk);
      k++;
      if (bus.multDone === 1'b1) seen = 1;
      else begin
        if (bus.Hi !== cur_hi || bus.Lo !== cur_lo) hold_ok = 0;
        if (bus.multBusy !== 1'b1) busy_ok = 0;
      end
    end
    n_vec++;
    if (!seen || sb.size() == 0) begin
      n_err++;
      $display("FAIL %s done: seen=%0d queued=%0d, required multDone with a queued result",
               name, seen, sb.size());
      sb.delete();
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if (k != e.lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles, required %0d (uns=%0d)", name, k, e.lat, e.uns);
    end
    n_vec++;
    if (bus.Hi !== e.hi) begin
      n_err++;
      $display("FAIL %s Hi: got %h, required %h", name, bus.Hi, e.hi);
    end
    n_vec++;
    if (bus.Lo !== e.lo) begin
      n_err++;
      $display("FAIL %s Lo: got %h, required %h", name, bus.Lo, e.lo);
    end
    n_vec++;
    if (!hold_ok) begin
      n_err++;
      $display("FAIL %s hold: Hi/Lo changed before completion, required %h/%h held", name, cur_hi, cur_lo);
    end
    n_vec++;
    if (!busy_ok || bus.multBusy !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy: run-busy ok=%0d, busy in done=%b, required 1 then 0", name, busy_ok, bus.multBusy);
    end
    cur_hi = e.hi;
    cur_lo = e.lo;
  endtask

  task automatic check_idle_outputs(input string name);
    n_vec++;
    if (bus.Hi !== '0 || bus.Lo !== '0 || bus.multBusy !== 1'b0 || bus.multDone !== 1'b0) begin
      n_err++;
      $display("FAIL %s: Hi=%h Lo=%h busy=%b done=%b, required all 0",
               name, bus.Hi, bus.Lo, bus.multBusy, bus.multDone);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.multStart = 1'b0;
    bus.A = '0;
    bus.B = '0;
`ifdef MULT_MULTU_EN
    bus.isUnsigned = 1'b0;
`endif
    #12;
    check_idle_outputs("reset_state");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_signed();
    drive_start(32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    wait_check("s_7x-3");
    @(negedge clk);
    drive_start(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000);
    wait_check("s_minxmin");
    @(negedge clk);
    drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h1);
    wait_check("s_-1x-1");
    @(negedge clk);
    drive_start(32'h1234_5678, 32'h0, 1'b0, 32'h0, 32'h0);
    wait_check("s_zero");
  endtask

  task automatic test_restart();
    int d0;
    @(negedge clk);
    drive_start(32'd5, 32'd5, 1'b0, 32'h0, 32'd25);
    repeat (9) @(negedge clk);
    void'(sb.pop_back());
    d0 = done_cnt;
    drive_start(32'd3, 32'd4, 1'b0, 32'h0, 32'd12);
    wait_check("restart");
    repeat (3) @(negedge clk);
    n_vec++;
    if (done_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL restart_done_count: got %0d pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] p;
    @(negedge clk);
    p = model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    drive_start(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, p[2*W-1:W], p[W-1:0]);
    wait_check("b2b_first");
    // start again in the DONE cycle
    p = model(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    drive_start(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, p[2*W-1:W], p[W-1:0]);
    wait_check("b2b_second");
  endtask

  task automatic test_random();
    logic [W-1:0]   a, b;
    logic [2*W-1:0] p;
    for (int i = 0; i < 6; i++) begin
      a = $urandom();
      b = $urandom();
      p = model(a, b, 1'b0);
      @(negedge clk);
      drive_start(a, b, 1'b0, p[2*W-1:W], p[W-1:0]);
      wait_check("random");
    end
  endtask

  task automatic test_reset_abort();
    int             d0;
    logic [2*W-1:0] p;
    @(negedge clk);
    drive_start(32'h0001_1111, 32'h0002_2222, 1'b0, 32'h0, 32'h0);
    repeat (14) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("reset_abort_async");
    sb.delete();
    cur_hi = '0;
    cur_lo = '0;
    d0 = done_cnt;
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    n_vec++;
    if (done_cnt != d0) begin
      n_err++;
      $display("FAIL reset_abort_no_done: got %0d pulses, required 0", done_cnt - d0);
    end
    p = model(32'd9, 32'hFFFF_FFF7, 1'b0);
    drive_start(32'd9, 32'hFFFF_FFF7, 1'b0, p[2*W-1:W], p[W-1:0]);
    wait_check("after_abort");
  endtask

`ifdef MULT_MULTU_EN
  task automatic test_unsigned();
    logic [W-1:0]   a, b;
    logic [2*W-1:0] p;
    @(negedge clk);
    drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_check("u_-1x-1");
    @(negedge clk);
    drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h1);
    wait_check("s_after_u");
    for (int i = 0; i < 3; i++) begin
      a = $urandom() | 32'h8000_0000;
      b = $urandom();
      p = model(a, b, 1'b1);
      @(negedge clk);
      drive_start(a, b, 1'b1, p[2*W-1:W], p[W-1:0]);
      wait_check("u_random");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_signed();
    test_restart();
    test_back_to_back();
    test_random();
    test_reset_abort();
`ifdef MULT_MULTU_EN
    test_unsigned();
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
